// File: rtl/uart_transmitter.sv
// UART transmit engine: serialises one parallel word per frame as start, data (LSB first),
// optional parity and stop bit(s), with the bit period derived from a runtime divide factor.
module uart_transmitter #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [31:0]          DIV_FACTOR,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [31:0]           r_period;
    logic [31:0]           r_baud_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_tx_done;

    logic                  w_bit_end;
    logic                  w_last_data;
    logic                  w_last_stop;
    logic [31:0]           w_period_in;
    logic                  w_tx_next;
    logic                  w_done_next;

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready. tx_ready is a
    // pure function of the state (high only in IDLE); the producer holds tx_valid and tx_data
    // until it sees the transfer, and valid while not ready is simply ignored.

    assign w_bit_end   = (r_baud_cnt == r_period - 32'd1);
    assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
    assign w_period_in = (DIV_FACTOR < 32'd2) ? 32'd2 : DIV_FACTOR;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Line value for the next bit period; registered below so tx never glitches.
    always_comb begin
        w_tx_next   = r_tx;
        w_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = tx_valid ? 1'b0 : 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_next = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (w_last_data) begin
                        w_tx_next = (PARITY_EN != 0) ? r_parity : 1'b1;
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_next = 1'b1;
                end
            end
            S_STOP: begin
                w_tx_next   = 1'b1;
                w_done_next = w_bit_end && w_last_stop;
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        tx_ready    = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        tx          = r_tx;
        tx_done     = r_tx_done;
        o_dbg_state = r_state;
    end

    // During DATA, r_shift[0] is the bit currently on the line.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_baud_cnt <= 32'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_period   <= 32'd2;
            r_parity   <= 1'b0;
        end else begin
            r_tx      <= w_tx_next;
            r_tx_done <= w_done_next;
            if (r_state == S_IDLE) begin
                r_baud_cnt <= 32'd0;
                r_bit_cnt  <= 4'd0;
                if (tx_valid) begin
                    r_shift  <= tx_data;
                    r_period <= w_period_in;
                    r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
                end
            end else if (w_bit_end) begin
                r_baud_cnt <= 32'd0;
                if (r_state == S_DATA && !w_last_data) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= r_shift >> 1;
                end else if (r_state == S_STOP && !w_last_stop) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else begin
                    r_bit_cnt <= 4'd0;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three frame formats (8N1, 8E1, 8O2) driven with directed and
// random words; each frame's line waveform comes from a bit-list model expanded per cycle.
module tb_uart_transmitter;

    logic        clk_in;
    logic        reset;
    logic [2:0]  valid_r;
    logic [7:0]  data_r [3];
    logic [31:0] div_r  [3];
    wire  [2:0]  tx_w;
    wire  [2:0]  ready_w;
    wire  [2:0]  busy_w;
    wire  [2:0]  done_w;
    wire  [2:0]  st0, st1, st2;

    int n_asserts = 0;
    int n_fail    = 0;
    int pen [3];
    int pod [3];
    int stb [3];
    logic [0:0] exp_q [$];

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk_in(clk_in), .reset(reset), .DIV_FACTOR(div_r[0]), .tx_data(data_r[0]),
        .tx_valid(valid_r[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .tx_done(done_w[0]), .o_dbg_state(st0));

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk_in(clk_in), .reset(reset), .DIV_FACTOR(div_r[1]), .tx_data(data_r[1]),
        .tx_valid(valid_r[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .tx_done(done_w[1]), .o_dbg_state(st1));

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
        .clk_in(clk_in), .reset(reset), .DIV_FACTOR(div_r[2]), .tx_data(data_r[2]),
        .tx_valid(valid_r[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .tx_done(done_w[2]), .o_dbg_state(st2));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame = list of line bits, each held for p cycles.
    function automatic void build_frame(input int idx, input logic [7:0] data, input int p);
        logic bits [$];
        int   ones;
        ones = $countones(data);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen[idx] != 0) begin
            if (pod[idx] != 0) bits.push_back((ones % 2) == 0);
            else               bits.push_back((ones % 2) == 1);
        end
        for (int s = 0; s < stb[idx]; s++) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[b]) begin
            for (int c = 0; c < p; c++) exp_q.push_back(bits[b]);
        end
    endfunction

    task automatic run_frame(input int idx, input logic [7:0] data, input int div,
                             input bit keep_valid, input int new_div);
        int       waited;
        int       p;
        int       n;
        logic     exp_bit;
        waited = 0;
        while (ready_w[idx] !== 1'b1 && waited < 500) begin
            @(negedge clk_in);
            waited++;
        end
        chk($sformatf("ready_wait u%0d", idx), 32'(waited < 500), 32'd1);
        if (waited >= 500) return;
        p = (div < 2) ? 2 : div;
        build_frame(idx, data, p);
        n = exp_q.size();
        data_r[idx]  = data;
        div_r[idx]   = div;
        valid_r[idx] = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            if (k == 0 && !keep_valid) valid_r[idx] = 1'b0;
            if (k == 5 && new_div > 0) div_r[idx] = new_div;
            exp_bit = exp_q.pop_front();
            chk($sformatf("tx_bit u%0d d%0h k%0d", idx, data, k), 32'(tx_w[idx]), 32'(exp_bit));
            chk($sformatf("ready_low u%0d k%0d", idx, k), 32'(ready_w[idx]), 32'd0);
            chk($sformatf("busy_high u%0d k%0d", idx, k), 32'(busy_w[idx]), 32'd1);
            chk($sformatf("done_low u%0d k%0d", idx, k), 32'(done_w[idx]), 32'd0);
        end
        @(negedge clk_in);
        chk($sformatf("end_ready u%0d", idx), 32'(ready_w[idx]), 32'd1);
        chk($sformatf("end_done u%0d", idx), 32'(done_w[idx]), 32'd1);
        chk($sformatf("end_busy u%0d", idx), 32'(busy_w[idx]), 32'd0);
        chk($sformatf("end_tx u%0d", idx), 32'(tx_w[idx]), 32'd1);
        if (!keep_valid) begin
            @(negedge clk_in);
            chk($sformatf("done_pulse u%0d", idx), 32'(done_w[idx]), 32'd0);
            chk($sformatf("idle_tx u%0d", idx), 32'(tx_w[idx]), 32'd1);
        end
    endtask

    initial begin
        pen = '{0, 1, 1};
        pod = '{0, 0, 1};
        stb = '{1, 1, 2};
        reset   = 1'b1;
        valid_r = 3'b000;
        for (int i = 0; i < 3; i++) begin
            data_r[i] = 8'h00;
            div_r[i]  = 32'd4;
        end
        repeat (3) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx u%0d", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("rst_ready u%0d", i), 32'(ready_w[i]), 32'd1);
            chk($sformatf("rst_busy u%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_done u%0d", i), 32'(done_w[i]), 32'd0);
        end

        // reset wins over a simultaneous valid
        data_r[0]  = 8'h77;
        valid_r[0] = 1'b1;
        @(negedge clk_in);
        chk("rstvalid_ready", 32'(ready_w[0]), 32'd1);
        chk("rstvalid_busy", 32'(busy_w[0]), 32'd0);
        chk("rstvalid_tx", 32'(tx_w[0]), 32'd1);
        reset      = 1'b0;
        valid_r[0] = 1'b0;
        @(negedge clk_in);
        chk("rstvalid_after_busy", 32'(busy_w[0]), 32'd0);
        chk("rstvalid_after_tx", 32'(tx_w[0]), 32'd1);

        run_frame(0, 8'hA5, 4, 1'b0, 0);
        run_frame(1, 8'hA5, 4, 1'b0, 0);
        run_frame(2, 8'hA5, 4, 1'b0, 0);
        run_frame(0, 8'h01, 3, 1'b1, 0);
        run_frame(0, 8'hFF, 3, 1'b0, 0);
        run_frame(0, 8'h55, 1, 1'b0, 0);
        run_frame(0, 8'h55, 0, 1'b0, 0);

        // reset during data bit 3 of an 0xA5 frame at four cycles per bit
        data_r[0]  = 8'hA5;
        div_r[0]   = 32'd4;
        valid_r[0] = 1'b1;
        @(negedge clk_in);
        valid_r[0] = 1'b0;
        repeat (17) @(negedge clk_in);
        chk("midrst_bit3", 32'(tx_w[0]), 32'd0);
        chk("midrst_busy_before", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        chk("midrst_tx", 32'(tx_w[0]), 32'd1);
        chk("midrst_ready", 32'(ready_w[0]), 32'd1);
        chk("midrst_busy", 32'(busy_w[0]), 32'd0);
        chk("midrst_done", 32'(done_w[0]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            chk($sformatf("midrst_quiet_done c%0d", c), 32'(done_w[0]), 32'd0);
            chk($sformatf("midrst_quiet_tx c%0d", c), 32'(tx_w[0]), 32'd1);
        end
        run_frame(0, 8'h3C, 4, 1'b0, 0);

        // divide factor changes mid-frame; the frame in flight keeps its latched period
        run_frame(2, 8'hC3, 4, 1'b0, 8);
        run_frame(2, 8'h5A, 8, 1'b0, 0);

        for (int r = 0; r < 15; r++) begin
            int         idx;
            logic [7:0] d;
            int         dv;
            idx = $urandom_range(0, 2);
            d   = 8'($urandom_range(0, 255));
            dv  = $urandom_range(0, 6);
            run_frame(idx, d, dv, 1'($urandom_range(0, 1)) && (r != 14), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
